// File: rtl/ecc_pkg.sv
// Shared field-arithmetic constants and types for the ECC datapath blocks.
// Used by operand_mux_pipe (optional 2-entry skid buffer via OPMUX_SKID_EN).
`timescale 1ns/1ps
package ecc_pkg;

  localparam int FE_WIDTH    = 255;
  localparam int ADD_SRC_NUM = 4;
  localparam int MUL_SRC_NUM = 11;

  typedef logic [FE_WIDTH-1:0] fe_t;

endpackage

// File: rtl/operand_mux_pipe_if.sv
// Request/response bundle for operand_mux_pipe: flat source bus plus select in,
// selected operand with range-error flag out.
`timescale 1ns/1ps
interface operand_mux_pipe_if #(
  parameter int WIDTH  = 255,
  parameter int NUM_IN = 11,
  parameter int SEL_W  = 4
);
  // Handshake: a beat moves on a rising clk edge where valid && ready; the
  // sender holds its payload and valid until that edge, and valid never
  // depends on ready.
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_sel_err;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_sel_err, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_sel_err, out_valid
  );
endinterface

// File: rtl/opmux_skid.sv
// Two-entry skid buffer with a registered ready, so upstream ready has no
// combinational path from downstream ready.
`timescale 1ns/1ps
module opmux_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;
  logic [1:0]   count_nxt;
  logic         ready_q;
  logic         push;
  logic         pop;

  // Ready is gated by reset so it reads 0 while held in reset and 1 right after.
  assign in_ready  = rst_n & ready_q;
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count   <= count_nxt;
      ready_q <= (count_nxt != 2'd2);
    end
  end
endmodule

// File: rtl/operand_mux_pipe.sv
// Selects one of NUM_IN operands into a one-cycle valid/ready output stage.
// Define OPMUX_SKID_EN for a 2-entry skid buffer with registered in_ready.
`timescale 1ns/1ps
module operand_mux_pipe
  import ecc_pkg::*;
#(
  parameter int WIDTH  = FE_WIDTH,
  parameter int NUM_IN = MUL_SRC_NUM,
  parameter int SEL_W  = 4
) (
  input logic               clk,
  input logic               rst_n,
  operand_mux_pipe_if.slave bus
);
  logic             sel_ok;
  logic [SEL_W-1:0] sel_idx;
  logic [WIDTH:0]   mux_word;

  // Payload is {sel_err, data}; out-of-range selects are clamped to 0 so the
  // part-select never reaches past the bus, then the data is forced to zero.
  always_comb begin
    sel_ok   = (int'(bus.in_sel) < NUM_IN);
    sel_idx  = sel_ok ? bus.in_sel : '0;
    mux_word = sel_ok ? {1'b0, bus.in_data[int'(sel_idx)*WIDTH +: WIDTH]}
                      : {1'b1, {WIDTH{1'b0}}};
  end

`ifdef OPMUX_SKID_EN
  logic [WIDTH:0] skid_out;

  opmux_skid #(.W(WIDTH + 1)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (mux_word),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (skid_out)
  );

  assign bus.out_sel_err = skid_out[WIDTH];
  assign bus.out_data    = skid_out[WIDTH-1:0];
`else
  logic [WIDTH:0] out_q;
  logic           valid_q;
  logic           accept;

  assign bus.in_ready    = rst_n & (~valid_q | bus.out_ready);
  assign accept          = bus.in_valid & bus.in_ready;
  assign bus.out_valid   = valid_q;
  assign bus.out_sel_err = out_q[WIDTH];
  assign bus.out_data    = out_q[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else if (accept) begin
      out_q   <= mux_word;
      valid_q <= 1'b1;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_operand_mux_pipe.sv
// Scoreboard bench for operand_mux_pipe: directed tests on the default
// configuration plus a random valid/ready run on an 8-bit, 4-source instance.
`timescale 1ns/1ps
module tb_operand_mux_pipe;
  import ecc_pkg::*;

  localparam int W  = FE_WIDTH;
  localparam int N  = MUL_SRC_NUM;
  localparam int S  = 4;
  localparam int W2 = 8;
  localparam int N2 = 4;
  localparam int S2 = 2;
`ifdef OPMUX_SKID_EN
  localparam int ACC_EXP = 2;
`else
  localparam int ACC_EXP = 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  operand_mux_pipe_if #(.WIDTH(W),  .NUM_IN(N),  .SEL_W(S))  ifa ();
  operand_mux_pipe_if #(.WIDTH(W2), .NUM_IN(N2), .SEL_W(S2)) ifb ();

  operand_mux_pipe #(.WIDTH(W),  .NUM_IN(N),  .SEL_W(S))  dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  operand_mux_pipe #(.WIDTH(W2), .NUM_IN(N2), .SEL_W(S2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int checks = 0;
  int errors = 0;
  logic [W:0]  exp_q[$];
  logic [W2:0] exp_b_q[$];

  task automatic chk(input string name, input logic [W:0] got, input logic [W:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // driver: called just after a rising edge, returns just after the accepting edge
  task automatic send_a(input logic [S-1:0] sel, input logic [W:0] exp);
    logic rdy;
    bit   done;
    done = 0;
    ifa.in_sel   = sel;
    ifa.in_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk); #4;
      rdy = ifa.in_ready;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back(exp);
        done = 1;
      end
    end
    #1;
    ifa.in_valid = 1'b0;
    if (!done) timeout_fail("send_a");
  endtask

  task automatic drain_a();
    bit done;
    done = 0;
    ifa.out_ready = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !ifa.out_valid) done = 1;
    end
    chk("drain_a_queue", W'(exp_q.size()), '0);
  endtask

  // monitor A: pops on each transfer, checks hold stability under backpressure
  logic       hold_a = 1'b0;
  logic [W:0] hold_val;
  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      hold_a = 1'b0;
    end else begin
      if (hold_a) begin
        chk("hold_valid", {{W{1'b0}}, ifa.out_valid}, {{W{1'b0}}, 1'b1});
        chk("hold_data", {ifa.out_sel_err, ifa.out_data}, hold_val);
      end
      if (ifa.out_valid && ifa.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_a_unexpected: got %h, expected no output", {ifa.out_sel_err, ifa.out_data});
        end else begin
          chk("out_a", {ifa.out_sel_err, ifa.out_data}, exp_q.pop_front());
        end
        hold_a = 1'b0;
      end else if (ifa.out_valid) begin
        hold_a   = 1'b1;
        hold_val = {ifa.out_sel_err, ifa.out_data};
      end else begin
        hold_a = 1'b0;
      end
    end
  end

  // monitor B
  always @(negedge clk) begin
    #4;
    if (rst_n && ifb.out_valid && ifb.out_ready) begin
      if (exp_b_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_b_unexpected: got %h, expected no output", {ifb.out_sel_err, ifb.out_data});
      end else begin
        chk("out_b", W'({ifb.out_sel_err, ifb.out_data}), W'(exp_b_q.pop_front()));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rdy;
    logic v;
    int   acc;
    time  t0;
    logic [S2-1:0] sel_b;

    ifa.in_valid = 1'b0; ifa.in_sel = '0; ifa.out_ready = 1'b1; ifa.in_data = '0;
    ifb.in_valid = 1'b0; ifb.in_sel = '0; ifb.out_ready = 1'b1; ifb.in_data = '0;
    for (int k = 0; k < N; k++) ifa.in_data[k*W +: W] = W'(k + 1);

    // reset held with a pending request
    ifa.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_out_valid", {{W{1'b0}}, ifa.out_valid}, '0);
      chk("rst_out_data", {ifa.out_sel_err, ifa.out_data}, '0);
      chk("rst_in_ready", {{W{1'b0}}, ifa.in_ready}, '0);
    end
    @(negedge clk);
    ifa.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {{W{1'b0}}, ifa.in_ready}, {{W{1'b0}}, 1'b1});
    @(posedge clk); #1;

    // back-to-back sweep, one transfer per cycle
    t0 = $time;
    for (int k = 0; k < N; k++) send_a(S'(k), {1'b0, W'(k + 1)});
    chk("sweep_cycles", W'(($time - t0) / 10), W'(N));

    // out-of-range selects, then a valid one
    send_a(4'd11, {1'b1, {W{1'b0}}});
    send_a(4'd15, {1'b1, {W{1'b0}}});
    send_a(4'd3,  {1'b0, W'(4)});
    drain_a();

    // backpressure: 5 cycles of offered requests with out_ready low
    @(posedge clk); #1;
    ifa.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      ifa.in_sel   = S'(5 + c);
      ifa.in_valid = 1'b1;
      @(negedge clk); #4;
      rdy = ifa.in_ready;
      @(posedge clk);
      if (rdy) begin
        exp_q.push_back({1'b0, W'(6 + c)});
        acc++;
      end
      #1;
    end
    ifa.in_valid = 1'b0;
    chk("bp_accepts", W'(acc), W'(ACC_EXP));
    drain_a();

    // mid-stream reset discards buffered requests
    @(posedge clk); #1;
    ifa.out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 2; c++) begin
      ifa.in_sel   = S'(7 + c);
      ifa.in_valid = 1'b1;
      @(negedge clk); #4;
      rdy = ifa.in_ready;
      @(posedge clk);
      if (rdy) acc++;
      #1;
    end
    ifa.in_valid = 1'b0;
    chk("buffered_before_rst", W'(acc), W'(ACC_EXP));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {{W{1'b0}}, ifa.out_valid}, '0);
    chk("midrst_in_ready", {{W{1'b0}}, ifa.in_ready}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    ifa.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk); #1;
      chk("after_rst_empty", {{W{1'b0}}, ifa.out_valid}, '0);
    end
    @(posedge clk); #1;
    send_a(4'd2, {1'b0, W'(3)});
    drain_a();

    // small configuration, random valid/ready
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      ifb.in_valid  = 1'($urandom_range(0, 1));
      ifb.in_sel    = S2'($urandom_range(0, N2 - 1));
      ifb.in_data   = (N2*W2)'($urandom);
      ifb.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk); #4;
      rdy   = ifb.in_ready;
      v     = ifb.in_valid;
      sel_b = ifb.in_sel;
      @(posedge clk);
      if (v && rdy) exp_b_q.push_back({1'b0, ifb.in_data[int'(sel_b)*W2 +: W2]});
      #1;
    end
    ifb.in_valid  = 1'b0;
    ifb.out_ready = 1'b1;
    for (int n = 0; n < 20 && (exp_b_q.size() != 0 || ifb.out_valid); n++) begin
      @(posedge clk); #1;
    end
    chk("drain_b_queue", W'(exp_b_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_mux_pipe.md
OPERAND_MUX_PIPE -- requirements
Module: operand_mux_pipe

Interface
REQ-001 Parameter WIDTH, default 255, operand width in bits (field element width).
REQ-002 Parameter NUM_IN, default 11, number of source operands (range 2..16).
REQ-003 Parameter SEL_W, default 4, select width; SHALL be at least clog2(NUM_IN).
REQ-004 clk  input  1  rising-edge clock, the block's only clock.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_data  input  NUM_IN*WIDTH  flat source bus; source k occupies bits [k*WIDTH +: WIDTH].
REQ-007 in_sel  input  SEL_W  source index for this transfer.
REQ-008 in_valid  input  1  upstream has a select request.
REQ-009 in_ready  output  1  block can accept a request this cycle.
REQ-010 out_data  output  WIDTH  selected operand.
REQ-011 out_sel_err  output  1  the request on out_data used an out-of-range select.
REQ-012 out_valid  output  1  out_data/out_sel_err are valid.
REQ-013 out_ready  input  1  downstream (adder/subtractor/multiplier) accepts output.

Function
REQ-014 A request SHALL be accepted when in_valid && in_ready is high at a rising edge of clk.
REQ-015 Accepted data SHALL be source in_data[in_sel], sampled at the accepting edge.
REQ-016 in_sel >= NUM_IN SHALL yield out_data = 0 and out_sel_err = 1; otherwise out_sel_err = 0.
REQ-017 Latency SHALL be one cycle: out_valid rises the cycle after acceptance if the output stage was empty or draining.
REQ-018 Output SHALL be held stable (data, err, valid) while out_valid && !out_ready.
REQ-019 A transfer out SHALL occur when out_valid && out_ready at a rising edge.
REQ-020 Simultaneous accept and drain on the same edge SHALL load the new request with no bubble.
REQ-021 Throughput SHALL be one transfer per cycle while out_ready stays high.
REQ-022 Requests SHALL leave in acceptance order; none dropped or duplicated.
REQ-023 in_data/in_sel changes while no accept occurs SHALL have no effect on outputs.

Reset
REQ-024 While rst_n is low: out_valid = 0, out_data = 0, out_sel_err = 0, all internal buffers empty.
REQ-025 in_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release.
REQ-026 Reset asserted mid-transfer SHALL discard all buffered requests immediately.

Configuration
REQ-027 Macro OPMUX_SKID_EN: when defined, a 2-entry skid buffer SHALL be inserted; in_ready SHALL be a register output (no combinational path from out_ready), and in_ready SHALL drop only when both entries are full.
REQ-028 Without OPMUX_SKID_EN: single output register; in_ready = !out_valid || out_ready (combinational).
REQ-029 Both builds SHALL give identical transfer order, data and error values; only in_ready timing differs.

Structure
REQ-030 Shared package ecc_pkg SHALL hold FE_WIDTH = 255, ADD_SRC_NUM = 4, MUL_SRC_NUM = 11 and the field-element typedef.
REQ-031 Skid storage SHALL be a sub-module opmux_skid (WIDTH+1 bits payload, valid/ready both sides), instantiated only under OPMUX_SKID_EN.
REQ-032 Selection SHALL be a single indexed part-select on in_data, no per-source case list.

Verification
REQ-033 Reset: rst_n low 3 cycles with in_valid = 1 -> out_valid = 0, out_data = 0, in_ready = 0; after release in_ready = 1.
REQ-034 Sweep: sources k loaded with value k+1, in_sel = 0..10 back-to-back, out_ready = 1 -> out_data = 1..11 one per cycle, out_sel_err = 0.
REQ-035 Range error: NUM_IN = 11, in_sel = 11 then 15 -> out_data = 0, out_sel_err = 1 for both; next in_sel = 3 -> out_sel_err = 0.
REQ-036 Backpressure: out_ready = 0 for 5 cycles with in_valid = 1 -> output stable, no loss; no-skid build accepts 1 request, skid build accepts 2; release -> order preserved.
REQ-037 Mid-stream reset: 2 requests buffered, rst_n pulsed low 1 cycle -> out_valid = 0, buffered requests never appear.
REQ-038 Parameter check: WIDTH = 8, NUM_IN = 4, SEL_W = 2 with random valid/ready toggling for 1000 cycles -> scoreboard matches, both macro settings.
